alu_ctrl_mdu: RTL and testbench
===============================

Name: alu_ctrl_mdu

Overview:
- Successor to the single-cycle ALU control decoder.
- Combinational decode now covers the full RV32I R-type and I-type ALU set, with a defined code for every input, plus an illegal flag.
- Adds an iterative multiply/divide unit (M extension) with a stall handshake to the core, parametrised in data width.
- Sits in the execute stage beside the main ALU; the core muxes mdu_result into writeback when mdu_sel is high.

Parameters:
- XLEN, 32, operand/result width (even, >=8).
- CTRL_W, 4, width of control_out.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  instruction in execute is valid.
- flush_i  in  1  kill instruction in execute (branch/trap).
- aluOp  in  2  main-decoder class: 00 load/store add, 01 branch sub, 10 R-type, 11 I-type ALU.
- fun7  in  7  instruction funct7 (imm[11:5] for I-type).
- fun3  in  3  instruction funct3.
- rs1  in  XLEN  operand A.
- rs2  in  XLEN  operand B.
- control_out  out  CTRL_W  ALU operation code.
- illegal_o  out  1  unsupported encoding.
- mdu_sel  out  1  instruction is an M-op; result comes from mdu_result.
- stall_o  out  1  hold the pipeline; execute inputs must stay stable.
- mdu_done  out  1  one-cycle pulse, mdu_result valid.
- mdu_result  out  XLEN  multiply/divide result.

Behaviour:
- ALU codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001, NOP 1111.
- Decode is combinational and independent of valid_i:
  - aluOp=00 gives ADD; aluOp=01 gives SUB.
  - aluOp=10 with fun7=0000000: fun3 000..111 gives ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - aluOp=10 with fun7=0100000: fun3=000 gives SUB, fun3=101 gives SRA.
  - aluOp=11: fun3 000..111 gives ADD, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND. Shifts use fun7=0000000, or 0100000 for SRAI; other fun3 values ignore fun7.
  - Any other combination gives NOP with illegal_o=1.
- M-op: aluOp=10 and fun7=0000001. In that case mdu_sel=1, control_out=NOP, illegal_o=0. fun3 selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- FSM states IDLE, CALC, DONE.
  - IDLE: on valid_i && M-op && !flush_i, latch operand magnitudes, sign flags and op, clear cnt, go to CALC.
  - CALC: one bit per cycle (shift-add multiply; restoring divide on magnitudes). cnt increments; after XLEN cycles go to DONE.
  - DONE: mdu_done=1, mdu_result driven; always return to IDLE.
- stall_o = valid_i && M-op && state!=DONE. Request seen in cycle T gives stall over T..T+XLEN and mdu_done at T+XLEN+1. The latency is fixed for every op, including the special cases below.
- DONE always returns to IDLE so the same held instruction is not re-issued. A back-to-back M-op starts on the cycle after DONE.
- Results:
  - MUL returns the low XLEN bits of the 2*XLEN product.
  - MULH, MULHSU and MULHU return the high XLEN bits, with signed, signed×unsigned and unsigned operand handling respectively.
  - Signed results are produced by two's-complement correction of the magnitude result.
- Divide special cases, result override at DONE:
  - Divisor 0: quotient = all ones, remainder = rs1.
  - Signed most-negative ÷ -1: quotient = rs1, remainder = 0.
  - Sign of remainder follows the dividend.
- flush_i in any state: next state IDLE; no mdu_done; stall_o=0 combinationally.
- Reset, including mid-operation: state IDLE, cnt 0, mdu_done=0, mdu_result=0, internal registers 0. stall_o follows its equation and is 0 when valid_i=0.
- mdu_result holds its last value outside DONE.

Decomposition:
- Package rv_alu_pkg holds:
  - ALU code localparams.
  - aluOp class constants.
  - FUNCT7_BASE/ALT/MULDIV.
  - M-op fun3 enum.
  - MDU state enum.
- One sub-module, mdu_iter: the XLEN-cycle shift/add/subtract datapath with start/done. alu_ctrl_mdu owns decode, FSM, sign handling and special cases.

Test Plan:
- Decode sweep over all aluOp/fun7/fun3 combinations -> table above, e.g. aluOp=10, fun7=0100000, fun3=101 gives 0111; aluOp=11, fun3=000, fun7=0100000 gives ADD; aluOp=10, fun7=0000010 gives 1111 with illegal_o=1.
- MUL rs1=7, rs2=-3 -> stall 33 cycles; mdu_done at T+33; result 0xFFFFFFEB. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0. DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. Latency still XLEN+1.
- DIV -7/2 -> -3; REM -7/2 -> -1.
- flush_i asserted at T+10 of a DIV -> stall_o drops the same cycle; no mdu_done; the next M-op completes normally.
- rst_n low at T+5 -> outputs reset asynchronously. After release, back-to-back MUL then DIV -> two done pulses at T+33 and T+67.

Source files
------------

// File: rtl/rv_alu_pkg.sv
// Shared constants and types for the execute-stage ALU control decoder and M-extension unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    M_MUL    = 3'd0,
    M_MULH   = 3'd1,
    M_MULHSU = 3'd2,
    M_MULHU  = 3'd3,
    M_DIV    = 3'd4,
    M_DIVU   = 3'd5,
    M_REM    = 3'd6,
    M_REMU   = 3'd7
  } mop_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // funct3 -> ALU code for the plain (funct7 = base) integer ops, shared by R- and I-type.
  function automatic logic [3:0] alu_base_op(input logic [2:0] f3);
    logic [3:0] code;
    case (f3)
      3'b000:  code = ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per step.
// Latency: XLEN step cycles after start; {hi,lo} = product, or hi = remainder / lo = quotient.
// Backpressure: none; the controller gates step and ignores the outputs until it has counted XLEN steps.
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic            div_q;
  logic [XLEN:0]   sum, sh, diff;

  // Multiply: conditional add into the high half, then shift {carry,hi,lo} right.
  // Divide: shift the next dividend bit into the partial remainder and try a subtract.
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    sh   = {hi_q, lo_q[XLEN-1]};
    diff = sh - {1'b0, b_q};
  end

  // Working registers: loaded on start, advanced one bit per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (start) begin
      hi_q  <= '0;
      lo_q  <= a_mag;
      b_q   <= b_mag;
      div_q <= is_div;
    end else if (step) begin
      if (div_q) begin
        if (!diff[XLEN]) begin
          hi_q <= diff[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_q <= sh[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_q <= sum[XLEN:1];
        lo_q <= {sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decode (combinational) plus iterative RV32M multiply/divide with pipeline stall.
// Latency: decode 0 cycles; M-op request in cycle T -> mdu_done pulse at T+XLEN+1.
// Backpressure: stall_o holds execute while an M-op is in flight; flush_i aborts with no done.
module alu_ctrl_mdu
  import rv_alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [1:0]        aluOp,
  input  logic [6:0]        fun7,
  input  logic [2:0]        fun3,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  output logic [CTRL_W-1:0] control_out,
  output logic              illegal_o,
  output logic              mdu_sel,
  output logic              stall_o,
  output logic              mdu_done,
  output logic [XLEN-1:0]   mdu_result
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  logic [3:0]      ctrl;
  logic            is_mop;
  mdu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            start, step;

  mop_e            op_in, op_q;
  logic            a_neg_d, b_neg_d, ovf_d;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            a_neg_q, b_neg_q, bzero_q, ovf_q;
  logic [XLEN-1:0] rs1_q, result_q, res_d;
  logic [XLEN-1:0] hi, lo, quo_s, rem_s;
  logic [2*XLEN-1:0] prod_s;

  // Instruction class decode; every input combination yields a code.
  always_comb begin
    ctrl      = ALU_NOP;
    illegal_o = 1'b0;
    is_mop    = 1'b0;
    case (aluOp)
      ALUOP_MEM:    ctrl = ALU_ADD;
      ALUOP_BRANCH: ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        if (fun7 == FUNCT7_BASE)                          ctrl = alu_base_op(fun3);
        else if (fun7 == FUNCT7_ALT && fun3 == 3'b000)    ctrl = ALU_SUB;
        else if (fun7 == FUNCT7_ALT && fun3 == 3'b101)    ctrl = ALU_SRA;
        else if (fun7 == FUNCT7_MULDIV)                   is_mop = 1'b1;
        else                                              illegal_o = 1'b1;
      end
      default: begin
        // I-type: only the shifts constrain imm[11:5].
        if (fun3 == 3'b001) begin
          if (fun7 == FUNCT7_BASE) ctrl = ALU_SLL;
          else                     illegal_o = 1'b1;
        end else if (fun3 == 3'b101) begin
          if (fun7 == FUNCT7_BASE)     ctrl = ALU_SRL;
          else if (fun7 == FUNCT7_ALT) ctrl = ALU_SRA;
          else                         illegal_o = 1'b1;
        end else begin
          ctrl = alu_base_op(fun3);
        end
      end
    endcase
  end

  assign control_out = CTRL_W'(ctrl);
  assign mdu_sel     = is_mop;

  // Operand sign handling: the iterative core only ever sees magnitudes.
  always_comb begin
    op_in   = mop_e'(fun3);
    a_neg_d = rs1[XLEN-1] && (op_in inside {M_MUL, M_MULH, M_MULHSU, M_DIV, M_REM});
    b_neg_d = rs2[XLEN-1] && (op_in inside {M_MUL, M_MULH, M_DIV, M_REM});
    a_mag   = a_neg_d ? -rs1 : rs1;
    b_mag   = b_neg_d ? -rs2 : rs2;
    ovf_d   = (op_in inside {M_DIV, M_REM}) && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    start    = 1'b0;
    step     = 1'b0;
    mdu_done = 1'b0;
    stall_o  = valid_i && is_mop && (state_q != MDU_DONE) && !flush_i;
    case (state_q)
      MDU_IDLE: begin
        if (valid_i && is_mop && !flush_i) begin
          start   = 1'b1;
          cnt_d   = '0;
          state_d = MDU_CALC;
        end
      end
      MDU_CALC: begin
        if (flush_i) begin
          state_d = MDU_IDLE;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = MDU_DONE;
        end
      end
      MDU_DONE: begin
        mdu_done = !flush_i;
        state_d  = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  // FSM state and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mdu_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .step   (step),
    .is_div (fun3[2]),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .hi     (hi),
    .lo     (lo)
  );

  // Sign-correct the magnitude result and apply the divide special cases.
  always_comb begin
    prod_s = (a_neg_q ^ b_neg_q) ? -{hi, lo} : {hi, lo};
    quo_s  = (a_neg_q ^ b_neg_q) ? -lo : lo;
    rem_s  = a_neg_q ? -hi : hi;
    case (op_q)
      M_MUL:                     res_d = prod_s[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU: res_d = prod_s[2*XLEN-1:XLEN];
      M_DIV, M_DIVU:             res_d = bzero_q ? '1 : (ovf_q ? rs1_q : quo_s);
      default:                   res_d = bzero_q ? rs1_q : (ovf_q ? '0 : rem_s);
    endcase
  end

  assign mdu_result = mdu_done ? res_d : result_q;

  // Per-operation context captured at start; last result held for the writeback mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= M_MUL;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      bzero_q  <= 1'b0;
      ovf_q    <= 1'b0;
      rs1_q    <= '0;
      result_q <= '0;
    end else begin
      if (start) begin
        op_q    <= op_in;
        a_neg_q <= a_neg_d;
        b_neg_q <= b_neg_d;
        bzero_q <= (rs2 == '0);
        ovf_q   <= ovf_d;
        rs1_q   <= rs1;
      end
      if (mdu_done) result_q <= res_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Self-checking bench for alu_ctrl_mdu: exhaustive decode sweep and scoreboarded M-ops.
// Latency: expects mdu_done XLEN+1 cycles after each request.
// Backpressure: holds execute inputs while stall_o is high, flush and reset exercised mid-op.
module tb_alu_ctrl_mdu;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 1;

  logic            clk, rst_n, valid_i, flush_i;
  logic [1:0]      aluOp;
  logic [6:0]      fun7;
  logic [2:0]      fun3;
  logic [31:0]     rs1, rs2;
  logic [3:0]      control_out;
  logic            illegal_o, mdu_sel, stall_o, mdu_done;
  logic [31:0]     mdu_result;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] last_res;

  typedef struct { logic [2:0] f3; logic [31:0] a; logic [31:0] b; } op_t;
  typedef struct { logic [31:0] res; int cyc; } exp_t;
  op_t  pend[$];
  exp_t exp_q[$];

  alu_ctrl_mdu #(.XLEN(XLEN), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .flush_i(flush_i),
    .aluOp(aluOp), .fun7(fun7), .fun3(fun3), .rs1(rs1), .rs2(rs2),
    .control_out(control_out), .illegal_o(illegal_o), .mdu_sel(mdu_sel),
    .stall_o(stall_o), .mdu_done(mdu_done), .mdu_result(mdu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected {code[3:0], illegal, mdu_sel}, written straight from the opcode table.
  function automatic logic [5:0] ref_dec(input int aop, input int f7, input int f3);
    logic [3:0] tab [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b1001, 4'b0011, 4'b0101, 4'b0001, 4'b0000};
    case (aop)
      0: return {4'b0010, 2'b00};
      1: return {4'b0110, 2'b00};
      2: begin
        if (f7 == 0)               return {tab[f3], 2'b00};
        if (f7 == 32 && f3 == 0)   return {4'b0110, 2'b00};
        if (f7 == 32 && f3 == 5)   return {4'b0111, 2'b00};
        if (f7 == 1)               return {4'b1111, 2'b01};
        return {4'b1111, 2'b10};
      end
      default: begin
        if (f3 == 1) return (f7 == 0) ? {4'b0100, 2'b00} : {4'b1111, 2'b10};
        if (f3 == 5) begin
          if (f7 == 0)  return {4'b0101, 2'b00};
          if (f7 == 32) return {4'b0111, 2'b00};
          return {4'b1111, 2'b10};
        end
        return {tab[f3], 2'b00};
      end
    endcase
  endfunction

  function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'(b);
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic drive_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    valid_i = 1'b1; aluOp = 2'b10; fun7 = 7'b0000001; fun3 = f3; rs1 = a; rs2 = b;
  endtask

  // Issue queued M-ops back to back, holding each while stalled; cycle 0 = first issue.
  task automatic run_pending();
    op_t o; exp_t e; int k; int stall_cnt; bit got;
    @(negedge clk);
    k = 0;
    while (pend.size() > 0) begin
      o = pend.pop_front();
      drive_mop(o.f3, o.a, o.b);
      exp_q.push_back('{ref_mdu(o.f3, o.a, o.b), k + LAT});
      stall_cnt = 0;
      got = 1'b0;
      for (int c = 0; c < LAT + 8 && !got; c++) begin
        #1;
        if (stall_o) stall_cnt++;
        if (mdu_done) begin
          got = 1'b1;
          e = exp_q.pop_front();
          chk($sformatf("result f3=%0d a=%h b=%h", o.f3, o.a, o.b), mdu_result, e.res);
          chk("done_cycle", k, e.cyc);
          chk("stall_cycles", stall_cnt, LAT);
          last_res = e.res;
        end
        @(negedge clk);
        k++;
      end
      if (!got) begin
        chk("done_timeout", 0, 1);
        exp_q.delete();
      end
    end
    valid_i = 1'b0;
    #1 chk("result_hold", mdu_result, last_res);
  endtask

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
    aluOp = 2'b00; fun7 = '0; fun3 = '0; rs1 = '0; rs2 = '0;
    last_res = '0;
    #1;
    chk("reset_done", mdu_done, 0);
    chk("reset_result", mdu_result, 0);
    chk("reset_stall", stall_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Combinational decode, with valid low to show independence from valid_i.
    for (int aop = 0; aop < 4; aop++)
      for (int f7 = 0; f7 < 128; f7++)
        for (int f3 = 0; f3 < 8; f3++) begin
          aluOp = 2'(aop); fun7 = 7'(f7); fun3 = 3'(f3);
          #1;
          chk($sformatf("decode op=%0d f7=%h f3=%0d", aop, f7, f3),
              {control_out, illegal_o, mdu_sel}, ref_dec(aop, f7, f3));
        end

    pend.push_back('{3'd0, 32'd7, 32'hFFFF_FFFD});
    pend.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    pend.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000});
    pend.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    pend.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF});
    pend.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF});
    pend.push_back('{3'd5, 32'd5, 32'd0});
    pend.push_back('{3'd7, 32'd5, 32'd0});
    pend.push_back('{3'd4, 32'hFFFF_FFFB, 32'd0});
    pend.push_back('{3'd6, 32'hFFFF_FFFB, 32'd0});
    pend.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2});
    pend.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2});
    for (int i = 0; i < 8; i++)
      pend.push_back('{3'($urandom_range(0, 7)), $urandom,
                       (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom});
    run_pending();

    // Flush a DIV ten cycles in: stall drops at once and no done appears.
    begin
      int seen;
      @(negedge clk);
      drive_mop(3'd4, 32'd1000, 32'd7);
      repeat (10) @(negedge clk);
      #1 chk("pre_flush_stall", stall_o, 1);
      flush_i = 1'b1;
      #1;
      chk("flush_stall", stall_o, 0);
      chk("flush_done", mdu_done, 0);
      @(negedge clk);
      flush_i = 1'b0; valid_i = 1'b0;
      seen = 0;
      for (int c = 0; c < LAT + 8; c++) begin
        #1 if (mdu_done) seen++;
        @(negedge clk);
      end
      chk("flush_no_done", seen, 0);
      chk("flush_result_hold", mdu_result, last_res);
    end
    pend.push_back('{3'd7, 32'd1000, 32'd7});
    run_pending();

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    drive_mop(3'd0, 32'd9, 32'd9);
    repeat (5) @(negedge clk);
    #1 chk("pre_reset_hold", mdu_result, last_res);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_result", mdu_result, 0);
    chk("arst_done", mdu_done, 0);
    chk("arst_stall_valid", stall_o, 1);
    valid_i = 1'b0;
    #1 chk("arst_stall_idle", stall_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;

    // Back-to-back after reset: done pulses at T+33 and T+67.
    pend.push_back('{3'd0, 32'd7, 32'hFFFF_FFFD});
    pend.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2});
    run_pending();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
